// File: rtl/bp_update_scheduler_if.sv
// Bundle between execute lanes, the update scheduler and the fetch-stage predictor update port.
// Latency: none (wires only).
// Backpressure: stall_o tells execute to hold its resolutions; pc_we_i paces the drain side.
//
// Signals:
//   pc_we_i                        predictor write enable (fetch PC write enable)
//   res_valid_i/taken/mispred/wasnt_br_i [1:0]  per-lane resolution flags, lane 0 older
//   res_pc_0/1_i, res_tgt_0/1_i    per-lane branch PC and resolved target
//   update_pc/tgt_o, last_br_o, update_pht/btb_o, wasnt_branch_o, wasnt_br_pc_o  head entry drive
//   clear_o                        predictor clear sweep active
//   stall_o                        execute must hold resolutions
interface bp_update_scheduler_if;
  logic        pc_we_i;
  logic [1:0]  res_valid_i;
  logic [31:0] res_pc_0_i;
  logic [31:0] res_pc_1_i;
  logic [31:0] res_tgt_0_i;
  logic [31:0] res_tgt_1_i;
  logic [1:0]  res_taken_i;
  logic [1:0]  res_mispred_i;
  logic [1:0]  res_wasnt_br_i;

  logic [31:0] update_pc_o;
  logic [31:0] update_tgt_o;
  logic        last_br_o;
  logic        update_pht_o;
  logic        update_btb_o;
  logic        wasnt_branch_o;
  logic [31:0] wasnt_br_pc_o;
  logic        clear_o;
  logic        stall_o;

  // Driven by execute + fetch side (testbench / surrounding pipeline).
  modport master (
    output pc_we_i, res_valid_i, res_pc_0_i, res_pc_1_i, res_tgt_0_i, res_tgt_1_i,
           res_taken_i, res_mispred_i, res_wasnt_br_i,
    input  update_pc_o, update_tgt_o, last_br_o, update_pht_o, update_btb_o,
           wasnt_branch_o, wasnt_br_pc_o, clear_o, stall_o
  );

  // Scheduler side.
  modport slave (
    input  pc_we_i, res_valid_i, res_pc_0_i, res_pc_1_i, res_tgt_0_i, res_tgt_1_i,
           res_taken_i, res_mispred_i, res_wasnt_br_i,
    output update_pc_o, update_tgt_o, last_br_o, update_pht_o, update_btb_o,
           wasnt_branch_o, wasnt_br_pc_o, clear_o, stall_o
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Serialises two-lane branch resolutions into the single predictor update port via an in-order FIFO.
// Latency: 1 cycle enqueue-to-head; head pops on each cycle with pc_we_i high.
// Backpressure: stall_o high during the clear sweep or when fewer than two free slots remain.
//
// Optional feature macro: BP_CLEAR_SWEEP_EN builds the post-reset predictor clear sweep
// (CLEAR -> RUN, 2^ABITS cycles). Without it reset enters RUN and clear_o/clear_idx_o are 0.
//
// Ports:
//   clock_i      clock
//   reset_n_i    asynchronous active-low reset
//   bus          bp_update_scheduler_if.slave (resolution inputs, head outputs, clear_o, stall_o)
//   clear_idx_o  predictor index currently being cleared
module bp_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int ABITS = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  bp_update_scheduler_if.slave bus,
  output logic [ABITS-1:0]     clear_idx_o
);

  localparam int PW = $clog2(DEPTH);
  // Stall once fewer than two slots are free so a dual enqueue can never overflow.
  localparam logic [PW:0] STALL_THR = (PW+1)'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        wasnt_br;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic          run;
  logic          stall;
  logic          hv;
  logic          en0;
  logic          en1;
  logic          deq;
  logic [PW:0]   enq_n;
  entry_t        lane0;
  entry_t        lane1;
  entry_t        head;

`ifdef BP_CLEAR_SWEEP_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t           state;
  logic [ABITS-1:0] clear_idx;
  logic             clear_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_CLEAR;
      clear_idx <= '0;
      clear_q   <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Index advances every cycle regardless of pc_we_i; last index wraps back to 0.
          clear_idx <= clear_idx + ABITS'(1);
          if (clear_idx == '1) begin
            state   <= ST_RUN;
            clear_q <= 1'b0;
          end
        end
        ST_RUN:  ;
        default: begin
          state   <= ST_RUN;
          clear_q <= 1'b0;
        end
      endcase
    end
  end

  assign run         = (state == ST_RUN);
  assign bus.clear_o = clear_q;
  assign clear_idx_o = clear_idx;
`else
  assign run         = 1'b1;
  assign bus.clear_o = 1'b0;
  assign clear_idx_o = '0;
`endif

  assign stall = !run || (count > STALL_THR);
  assign hv    = (count != '0);

  assign lane0 = '{pc: bus.res_pc_0_i, tgt: bus.res_tgt_0_i,
                   taken: bus.res_taken_i[0], wasnt_br: bus.res_wasnt_br_i[0]};
  assign lane1 = '{pc: bus.res_pc_1_i, tgt: bus.res_tgt_1_i,
                   taken: bus.res_taken_i[1], wasnt_br: bus.res_wasnt_br_i[1]};

  // A mispredicted lane 0 means lane 1 executed down the wrong path.
  assign en0   = !stall && bus.res_valid_i[0];
  assign en1   = !stall && bus.res_valid_i[1] && !(bus.res_valid_i[0] && bus.res_mispred_i[0]);
  assign enq_n = (PW+1)'(en0) + (PW+1)'(en1);
  assign deq   = run && hv && bus.pc_we_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + enq_n[PW-1:0];
      rd_ptr <= rd_ptr + PW'(deq);
      count  <= count + enq_n - (PW+1)'(deq);
    end
  end

  // Storage needs no reset: every head output is gated by hv.
  always_ff @(posedge clock_i) begin
    if (en0) mem[wr_ptr] <= lane0;
    if (en1) mem[wr_ptr + PW'(en0)] <= lane1;
  end

  assign head = mem[rd_ptr];

  assign bus.update_pc_o    = hv ? head.pc  : 32'h0;
  assign bus.update_tgt_o   = hv ? head.tgt : 32'h0;
  assign bus.wasnt_br_pc_o  = hv ? head.pc  : 32'h0;
  assign bus.update_pht_o   = hv && !head.wasnt_br;
  assign bus.update_btb_o   = hv && !head.wasnt_br && head.taken;
  assign bus.wasnt_branch_o = hv && head.wasnt_br;
  assign bus.last_br_o      = hv && head.taken;
  assign bus.stall_o        = stall;

endmodule

// File: tb/tb_bp_update_scheduler.sv
module tb_bp_update_scheduler;

  localparam int DEPTH = 4;
  localparam int ABITS = 4;
`ifdef BP_CLEAR_SWEEP_EN
  localparam logic SWEEP = 1'b1;
`else
  localparam logic SWEEP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [ABITS-1:0] clear_idx;

  bp_update_scheduler_if bus ();

  bp_update_scheduler #(.DEPTH(DEPTH), .ABITS(ABITS)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .bus         (bus),
    .clear_idx_o (clear_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  tk;
    logic [1:0]  mp;
    logic [1:0]  wb;
    logic        we;
    logic [31:0] e_pc;
    logic        e_pht;
    logic        e_btb;
    logic        e_lbr;
    logic        e_wbr;
    logic        e_stall;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] tk, input logic [1:0] mp, input logic [1:0] wb,
                       input logic we);
    bus.res_valid_i    = v;
    bus.res_pc_0_i     = pc0;
    bus.res_pc_1_i     = pc1;
    bus.res_tgt_0_i    = pc0 + 32'h1000;
    bus.res_tgt_1_i    = pc1 + 32'h1000;
    bus.res_taken_i    = tk;
    bus.res_mispred_i  = mp;
    bus.res_wasnt_br_i = wb;
    bus.pc_we_i        = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pc"},   bus.update_pc_o, 32'h0);
    chk({tag, "_tgt"},  bus.update_tgt_o, 32'h0);
    chk({tag, "_wpc"},  bus.wasnt_br_pc_o, 32'h0);
    chk({tag, "_pht"},  32'(bus.update_pht_o), 32'h0);
    chk({tag, "_btb"},  32'(bus.update_btb_o), 32'h0);
    chk({tag, "_lbr"},  32'(bus.last_br_o), 32'h0);
    chk({tag, "_wbr"},  32'(bus.wasnt_branch_o), 32'h0);
    chk({tag, "_idx"},  32'(clear_idx), 32'h0);
    chk({tag, "_clr"},  32'(bus.clear_o), 32'(SWEEP));
    chk({tag, "_stall"}, 32'(bus.stall_o), 32'(SWEEP));
  endtask

  initial begin
    // {v, pc0, pc1, tk, mp, wb, we, exp_pc, pht, btb, lbr, wbr, stall}
    vecs[0]  = '{2'b11, 32'h100, 32'h104, 2'b01, 2'b00, 2'b00, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 32'h200, 32'h204, 2'b00, 2'b01, 2'b00, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 32'h30,  32'h0,   2'b00, 2'b00, 2'b01, 1'b0, 32'h30,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 32'h400, 32'h404, 2'b11, 2'b00, 2'b00, 1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 32'h408, 32'h0,   2'b00, 2'b00, 2'b00, 1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{2'b11, 32'h500, 32'h504, 2'b11, 2'b00, 2'b00, 1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h404, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 32'h600, 32'h0,   2'b01, 2'b00, 2'b00, 1'b1, 32'h408, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h600, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0);
    #2;
    chk_idle("reset");

    // Release reset mid-cycle.
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    if (SWEEP) begin
      for (int i = 0; i < (1 << ABITS); i++) begin
        chk($sformatf("sweep%0d_idx", i), 32'(clear_idx), 32'(i));
        chk($sformatf("sweep%0d_stall", i), 32'(bus.stall_o), 32'h1);
        chk($sformatf("sweep%0d_clr", i), 32'(bus.clear_o), 32'h1);
        step();
      end
    end else begin
      step();
    end
    chk("run_clr", 32'(bus.clear_o), 32'h0);
    chk("run_stall", 32'(bus.stall_o), 32'h0);
    chk("run_idx", 32'(clear_idx), 32'h0);

    // Directed vectors; each result observed one cycle after its inputs are applied.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].v, vecs[i].pc0, vecs[i].pc1, vecs[i].tk, vecs[i].mp, vecs[i].wb, vecs[i].we);
      step();
      chk($sformatf("v%0d_pc", i), bus.update_pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_tgt", i), bus.update_tgt_o,
          (vecs[i].e_pc == 32'h0) ? 32'h0 : vecs[i].e_pc + 32'h1000);
      chk($sformatf("v%0d_wpc", i), bus.wasnt_br_pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_pht", i), 32'(bus.update_pht_o), 32'(vecs[i].e_pht));
      chk($sformatf("v%0d_btb", i), 32'(bus.update_btb_o), 32'(vecs[i].e_btb));
      chk($sformatf("v%0d_lbr", i), 32'(bus.last_br_o), 32'(vecs[i].e_lbr));
      chk($sformatf("v%0d_wbr", i), 32'(bus.wasnt_branch_o), 32'(vecs[i].e_wbr));
      chk($sformatf("v%0d_stall", i), 32'(bus.stall_o), 32'(vecs[i].e_stall));
    end

    // Queue three entries, then assert reset between edges.
    drive(2'b11, 32'h700, 32'h704, 2'b11, 2'b00, 2'b00, 1'b0);
    step();
    drive(2'b01, 32'h708, 32'h0, 2'b01, 2'b00, 2'b00, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("pre_rst_pc", bus.update_pc_o, 32'h700);
    chk("pre_rst_stall", 32'(bus.stall_o), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    step();
    rst_n = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b1);
    #1;
    chk("restart_idx0", 32'(clear_idx), 32'h0);
    step();
    chk("restart_idx1", 32'(clear_idx), SWEEP ? 32'h1 : 32'h0);
    chk("restart_stall", 32'(bus.stall_o), 32'(SWEEP));
    chk("restart_pht", 32'(bus.update_pht_o), 32'h0);
    chk("restart_pc", bus.update_pc_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
